regfile_scan_display: RTL and testbench

- Parametrised successor to the board-level register-file exercise block.
- Contains its own register file: 2^ADDR_W words of DATA_W bits, one write port and two read ports.
- Writes preset patterns on an edge-detected write strobe. Displays any byte of any register on LED_W LEDs.
- Adds an auto-scan mode that steps through every byte of every register at a programmable rate.
- Sits directly behind board switches/buttons; LED drives board LEDs.

---
 rtl/regfile_scan_display.sv | 138 +++++++++++++
 tb/tb_regfile_scan_display.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scan_display.sv
// Register-file exerciser: writes preset patterns on a write-strobe edge and shows any byte
// of any register on the LEDs, either picked by hand or stepped through by an auto-scan.
module regfile_scan_display #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned BSEL_W   = 2,
  parameter int unsigned SCAN_DIV = 25000000,
  parameter int unsigned LED_W    = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] Addr,
  input  logic              Write_Reg,
  input  logic [1:0]        C1,
  input  logic              C2,
  input  logic [BSEL_W-1:0] Byte_Sel,
  input  logic              Mode,
  output logic [LED_W-1:0]  LED,
  output logic              Busy,
  output logic [ADDR_W-1:0] Cur_Addr
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned CNT_W  = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {StManual, StScan, StWrite} state_e;

  state_e                        state;
  logic                          wr_q;
  logic [CNT_W-1:0]              scan_cnt;
  logic [ADDR_W-1:0]             scan_addr;
  logic [BSEL_W-1:0]             scan_byte;
  logic [DEPTH-1:0][DATA_W-1:0]  mem;

  logic              wr_edge;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] disp_word;
  logic [BSEL_W-1:0] disp_idx;
  logic [7:0]        disp_byte;
  logic [31:0]       pattern;
  logic [DATA_W-1:0] wr_data;
  logic              cnt_last;
  logic              byte_last;

  assign wr_edge = Write_Reg & ~wr_q;
  assign addr_a  = (state == StScan) ? scan_addr : Addr;

  // Register 0 is hard-wired to zero on both read ports.
  assign rd_a = (addr_a == '0) ? '0 : mem[addr_a];
  assign rd_b = (Addr == '0) ? '0 : mem[Addr];

  assign disp_word = (state == StScan) ? rd_a : (C2 ? rd_b : rd_a);
  assign disp_idx  = (state == StScan) ? scan_byte : Byte_Sel;

  // Byte indices past the top of the word fall through to zero.
  always_comb begin
    disp_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (disp_idx == BSEL_W'(i)) disp_byte = disp_word[8*i +: 8];
    end
  end

  always_comb begin
    pattern = 32'h0000_0000;
    case (C1)
      2'b00:   pattern = 32'h0000_0003;
      2'b01:   pattern = 32'h0000_0607;
      2'b11:   pattern = 32'h1111_1234;
      default: pattern = 32'h0000_0000;
    endcase
    wr_data = (C1 == 2'b10) ? '1 : DATA_W'(pattern);
  end

  assign cnt_last  = (scan_cnt == CNT_W'(SCAN_DIV - 1));
  assign byte_last = (scan_byte == BSEL_W'(NBYTES - 1));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= StManual;
      wr_q      <= 1'b1;
      scan_cnt  <= '0;
      scan_addr <= '0;
      scan_byte <= '0;
      mem       <= '0;
      LED       <= '0;
      Busy      <= 1'b0;
      Cur_Addr  <= '0;
    end else begin
      wr_q <= Write_Reg;
      Busy <= 1'b0;
      case (state)
        StManual: begin
          if (wr_edge) begin
            state <= StWrite;
            Busy  <= 1'b1;
          end else if (Mode) begin
            state     <= StScan;
            scan_cnt  <= '0;
            scan_addr <= '0;
            scan_byte <= '0;
          end
        end
        StScan: begin
          if (wr_edge) begin
            state <= StWrite;
            Busy  <= 1'b1;
          end else if (!Mode) begin
            state <= StManual;
          end else if (cnt_last) begin
            scan_cnt <= '0;
            if (byte_last) begin
              scan_byte <= '0;
              scan_addr <= scan_addr + 1'b1;
            end else begin
              scan_byte <= scan_byte + 1'b1;
            end
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        StWrite: begin
          if (Addr != '0) mem[Addr] <= wr_data;
          state <= Mode ? StScan : StManual;
        end
        default: state <= StManual;
      endcase
      // Display freezes for the single write cycle.
      if (state != StWrite) begin
        LED      <= LED_W'(disp_byte);
        Cur_Addr <= addr_a;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scan_display.sv
// Directed bench for regfile_scan_display: a 32-bit instance with a fast scan and a
// 64-bit / 8-register instance for the wide-word byte selects.
module tb_regfile_scan_display;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [4:0] Addr;
  logic       Write_Reg;
  logic [1:0] C1;
  logic       C2;
  logic [1:0] Byte_Sel;
  logic       Mode;
  logic [7:0] LED;
  logic       Busy;
  logic [4:0] Cur_Addr;

  logic [2:0] a64;
  logic       w64;
  logic [1:0] c1_64;
  logic       c2_64;
  logic [2:0] bs64;
  logic       mode64;
  logic [7:0] led64;
  logic       busy64;
  logic [2:0] cur64;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  regfile_scan_display #(
    .DATA_W(32), .ADDR_W(5), .BSEL_W(2), .SCAN_DIV(4), .LED_W(8)
  ) u_dut (
    .Clk(Clk), .Reset(Reset), .Addr(Addr), .Write_Reg(Write_Reg), .C1(C1), .C2(C2),
    .Byte_Sel(Byte_Sel), .Mode(Mode), .LED(LED), .Busy(Busy), .Cur_Addr(Cur_Addr)
  );

  regfile_scan_display #(
    .DATA_W(64), .ADDR_W(3), .BSEL_W(3), .SCAN_DIV(4), .LED_W(8)
  ) u_dut64 (
    .Clk(Clk), .Reset(Reset), .Addr(a64), .Write_Reg(w64), .C1(c1_64), .C2(c2_64),
    .Byte_Sel(bs64), .Mode(mode64), .LED(led64), .Busy(busy64), .Cur_Addr(cur64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [1:0] c);
    Addr = a;
    C1 = c;
    Write_Reg = 1'b1;
    @(negedge Clk);
    check("busy_hi", Busy, 1);
    Write_Reg = 1'b0;
    @(negedge Clk);
    check("busy_lo", Busy, 0);
  endtask

  initial begin
    int bcnt;
    int sa;
    int sb;
    Reset = 1'b0; Addr = '0; Write_Reg = 1'b0; C1 = '0; C2 = 1'b0; Byte_Sel = '0; Mode = 1'b0;
    a64 = '0; w64 = 1'b0; c1_64 = '0; c2_64 = 1'b0; bs64 = '0; mode64 = 1'b0;

    repeat (3) @(negedge Clk);
    check("rst_led", LED, 0);
    check("rst_busy", Busy, 0);
    check("rst_cur", Cur_Addr, 0);
    Reset = 1'b1;
    @(negedge Clk);

    // Manual write and byte select
    Byte_Sel = 2'd1;
    do_write(5'd3, 2'b01);
    @(negedge Clk);
    check("a3_b1", LED, 8'h06);
    Byte_Sel = 2'd0;
    @(negedge Clk);
    check("a3_b0", LED, 8'h07);
    check("a3_cur", Cur_Addr, 3);

    // Register 0 discards writes
    do_write(5'd0, 2'b10);
    for (int b = 0; b < 4; b++) begin
      Byte_Sel = 2'(b);
      @(negedge Clk);
      check($sformatf("r0_b%0d", b), LED, 8'h00);
    end
    C2 = 1'b1;
    @(negedge Clk);
    check("r0_portb", LED, 8'h00);

    // Port B vs port A
    C2 = 1'b0;
    do_write(5'd5, 2'b11);
    C2 = 1'b1; Byte_Sel = 2'd3;
    @(negedge Clk);
    check("a5_b3_pb", LED, 8'h11);
    Byte_Sel = 2'd0;
    @(negedge Clk);
    check("a5_b0_pb", LED, 8'h34);
    C2 = 1'b0; Byte_Sel = 2'd1;
    @(negedge Clk);
    check("a5_b1_pa", LED, 8'h12);

    // Held strobe writes once
    Addr = 5'd6; C1 = 2'b00; Byte_Sel = 2'd0; Write_Reg = 1'b1;
    bcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (Busy) bcnt++;
    end
    Write_Reg = 1'b0;
    check("hold_busy_cnt", bcnt, 1);
    @(negedge Clk);
    check("a6_b0", LED, 8'h03);

    // Strobe held through reset does not write on release
    Addr = 5'd5; C1 = 2'b10; Byte_Sel = 2'd0; Write_Reg = 1'b1; Reset = 1'b0;
    @(negedge Clk);
    check("rst2_led", LED, 0);
    Reset = 1'b1;
    bcnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (Busy) bcnt++;
    end
    check("rst2_busy_cnt", bcnt, 0);
    check("rst2_a5", LED, 8'h00);
    Write_Reg = 1'b0;
    @(negedge Clk);

    // Auto scan, including wrap from addr 31 byte 3 to addr 0 byte 0
    do_write(5'd1, 2'b00);
    Mode = 1'b1; Byte_Sel = 2'd2; C2 = 1'b1;
    @(negedge Clk);
    for (int i = 0; i < 527; i++) begin
      @(negedge Clk);
      sa = (i / 16) % 32;
      sb = (i / 4) % 4;
      check($sformatf("scan_cur_%0d", i), Cur_Addr, sa);
      check($sformatf("scan_led_%0d", i), LED, (sa == 1 && sb == 0) ? 8'h03 : 8'h00);
    end

    // Write during scan holds the scan position
    Addr = 5'd4; C1 = 2'b00; Write_Reg = 1'b1;
    @(negedge Clk);
    check("sw_busy_hi", Busy, 1);
    check("sw_cur0", Cur_Addr, 0);
    Write_Reg = 1'b0;
    @(negedge Clk);
    check("sw_busy_lo", Busy, 0);
    check("sw_cur1", Cur_Addr, 0);
    @(negedge Clk);
    check("sw_cur2", Cur_Addr, 0);
    check("sw_led2", LED, 8'h00);
    @(negedge Clk);
    check("sw_cur3", Cur_Addr, 1);
    check("sw_led3", LED, 8'h03);

    // Write edge wins over Mode 1->0 in the same cycle
    Addr = 5'd2; C1 = 2'b01; Byte_Sel = 2'd0; C2 = 1'b0; Mode = 1'b0; Write_Reg = 1'b1;
    @(negedge Clk);
    check("wm_busy_hi", Busy, 1);
    check("wm_cur0", Cur_Addr, 1);
    check("wm_led0", LED, 8'h03);
    Write_Reg = 1'b0;
    @(negedge Clk);
    check("wm_busy_lo", Busy, 0);
    check("wm_led_hold", LED, 8'h03);
    check("wm_cur_hold", Cur_Addr, 1);
    @(negedge Clk);
    check("wm_led_man", LED, 8'h07);
    check("wm_cur_man", Cur_Addr, 2);

    // 64-bit instance
    a64 = 3'd7; c1_64 = 2'b10; w64 = 1'b1;
    @(negedge Clk);
    check("w64_busy_hi", busy64, 1);
    w64 = 1'b0; bs64 = 3'd7;
    @(negedge Clk);
    check("w64_busy_lo", busy64, 0);
    @(negedge Clk);
    check("w64_ones_b7", led64, 8'hFF);
    c1_64 = 2'b11; w64 = 1'b1;
    @(negedge Clk);
    w64 = 1'b0; bs64 = 3'd4;
    @(negedge Clk);
    @(negedge Clk);
    check("w64_pat_b4", led64, 8'h00);
    bs64 = 3'd0;
    @(negedge Clk);
    check("w64_pat_b0", led64, 8'h34);
    bs64 = 3'd3;
    @(negedge Clk);
    check("w64_pat_b3", led64, 8'h11);
    check("w64_cur", cur64, 7);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
